// File: rtl/sync_gen_pkg.sv
// Shared types and default sizing for the periodic sync generator.
//   sync_state_t : FSM state encoding (IDLE, RUN)
//   DEF_*        : default parameter values used by sync_pulse_gen
package sync_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sync_state_t;

   localparam int DEF_PER_W      = 32;
   localparam int DEF_COUNT_W    = 32;
   localparam int DEF_PULSE_W    = 1;
   localparam int DEF_MIN_PERIOD = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Rising-edge detector with a registered copy of its input.
//   user_clk   in  : clock
//   user_rst_n in  : synchronous active-low reset
//   d          in  : level to watch
//   rise       out : d & ~d_registered (high in the first cycle d is seen high)
module sync_edge_det (
   input  logic user_clk,
   input  logic user_rst_n,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) d_q <= 1'b0;
      else             d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/sync_pulse_gen.sv
// Programmable periodic sync generator.
//   user_clk    in  : single clock
//   user_rst_n  in  : synchronous active-low reset
//   sync_period in  : interval in cycles (software register)
//   arm         in  : rising edge starts, low stops
//   ext_sync    in  : external realign pulse
//   sync_out    out : registered sync pulse, PULSE_W cycles high
//   sync_count  out : pulses since last arm, wraps
//   running     out : high while in RUN
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | stopped; waits for an arm rising edge with a legal period
// RUN   | interval timer active, one pulse at the start of each interval
module sync_pulse_gen
   import sync_gen_pkg::*;
#(
   parameter int PER_W      = DEF_PER_W,
   parameter int COUNT_W    = DEF_COUNT_W,
   parameter int PULSE_W    = DEF_PULSE_W,
   parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
   input  logic               user_clk,
   input  logic               user_rst_n,
   input  logic [PER_W-1:0]   sync_period,
   input  logic               arm,
   input  logic               ext_sync,
   output logic               sync_out,
   output logic [COUNT_W-1:0] sync_count,
   output logic               running
);

   localparam int              PT_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
   localparam logic [PT_W-1:0] PT_LOAD = PT_W'(PULSE_W - 1);
   localparam logic [PER_W-1:0] MIN_PER = PER_W'(MIN_PERIOD);

   generate
      if (PULSE_W < 1 || PULSE_W >= MIN_PERIOD) begin : g_bad_pulse_w
         $error("sync_pulse_gen: PULSE_W must satisfy 1 <= PULSE_W < MIN_PERIOD");
      end
   endgenerate

   sync_state_t        state, state_nxt;
   logic [PER_W-1:0]   tmr, tmr_nxt;
   logic [PT_W-1:0]    pt, pt_nxt;
   logic               sync_out_nxt;
   logic [COUNT_W-1:0] count_nxt;
   logic               arm_rise;
   logic               period_ok;

   sync_edge_det u_arm_edge (
      .user_clk   (user_clk),
      .user_rst_n (user_rst_n),
      .d          (arm),
      .rise       (arm_rise)
   );

   assign period_ok = (sync_period >= MIN_PER);

   // tmr is the interval down-counter: loaded with period-1 on the pulse
   // cycle, next interval starts when it reaches zero. The live sync_period is
   // only sampled at an interval start, so mid-interval writes wait their turn.
   // pt counts the remaining extra high cycles of the pulse; since
   // PULSE_W < MIN_PERIOD it always drains before the interval ends.
   always_comb begin
      state_nxt    = state;
      tmr_nxt      = tmr;
      pt_nxt       = pt;
      sync_out_nxt = 1'b0;
      count_nxt    = sync_count;
      case (state)
         IDLE: begin
            if (arm_rise) begin
               if (period_ok) begin
                  state_nxt    = RUN;
                  tmr_nxt      = sync_period - PER_W'(1);
                  pt_nxt       = PT_LOAD;
                  sync_out_nxt = 1'b1;
                  count_nxt    = COUNT_W'(1);
               end else begin
                  count_nxt = '0;
               end
            end
         end
         RUN: begin
            if (!arm) begin
               state_nxt = IDLE;
               tmr_nxt   = '0;
               pt_nxt    = '0;
            end else if (ext_sync || tmr == '0) begin
               // wrap and realign share one path so a coincident pair counts once
               if (period_ok) begin
                  tmr_nxt      = sync_period - PER_W'(1);
                  pt_nxt       = PT_LOAD;
                  sync_out_nxt = 1'b1;
                  count_nxt    = sync_count + COUNT_W'(1);
               end else begin
                  state_nxt = IDLE;
                  tmr_nxt   = '0;
                  pt_nxt    = '0;
               end
            end else begin
               tmr_nxt      = tmr - PER_W'(1);
               sync_out_nxt = (pt != '0);
               if (pt != '0) pt_nxt = pt - PT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         state      <= IDLE;
         tmr        <= '0;
         pt         <= '0;
         sync_out   <= 1'b0;
         sync_count <= '0;
         running    <= 1'b0;
      end else begin
         state      <= state_nxt;
         tmr        <= tmr_nxt;
         pt         <= pt_nxt;
         sync_out   <= sync_out_nxt;
         sync_count <= count_nxt;
         running    <= (state_nxt == RUN);
      end
   end

endmodule
